// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
// Consumes register-use info from decode and pipeline stages and produces:
//   fwd_a/fwd_b      EX operand source select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   *_stall          hold PC / IF-ID / ID-EX / EX-MEM registers
//   *_flush          insert bubble into IF-ID / ID-EX / MEM-WB
//   stall_cycles     saturating count of cycles with any stall
//   flush_events     saturating count of redirects acted on
//   proto_err        sticky data-bus protocol error (timeout or dropped mem_req)
// Inputs: clk, rst_n (async active-low), ID/EX source regs and read enables,
// EX/MEM/WB destination regs and write enables, ex_is_load, ex_redirect,
// mem_req/mem_ready handshake of the data bus.
module hazard_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [1:0]       id_rf_re,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_we,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_we,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             proto_err
);

  localparam int unsigned WC_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;
  logic redirect_act;
  logic any_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_rf_we && (mem_rd != 5'd0) && (mem_rd == src))
      return 2'b01;
    else if (wb_rf_we && (wb_rd != 5'd0) && (wb_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_is_load && ex_rf_we && (ex_rd != 5'd0) &&
                    ((id_rf_re[0] && (id_rs1 == ex_rd)) ||
                     (id_rf_re[1] && (id_rs2 == ex_rd)));

  // Stall/flush strobes are combinational so that hazards act in the same cycle.
  // While rst_n is low the pipeline is held in a bubble-filling, stall-free state.
  always_comb begin
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;
    redirect_act = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
      if (freeze) begin
        // EX is held, so a pending redirect stays asserted and is acted on later.
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        redirect_act = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign any_stall = pc_stall || ifid_stall || idex_stall || exmem_stall;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    proto_err_d = proto_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (any_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_act && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;

    // wait_cnt holds the number of consecutive freeze cycles completed, so the
    // timeout fires on the edge that completes the WAIT_TIMEOUT-th freeze cycle.
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_req) begin
          state_d     = RUN;
          proto_err_d = 1'b1;
        end else if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if ((state_d == MEM_WAIT) && (wait_cnt_d == WC_W'(WAIT_TIMEOUT)))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      proto_err_q <= proto_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances share all inputs, one with default
// parameters and one with CNT_W=4 / WAIT_TIMEOUT=4. A rule-level reference
// model predicts every output each cycle; directed steps cover the listed
// scenarios, followed by a randomized run.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0] id_rf_re;
  logic       ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
  logic       ex_redirect, mem_req, mem_ready;

  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic        pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s;
  logic        ifid_flush_s, idex_flush_s, memwb_flush_s;
  logic [31:0] stall_cycles, flush_events;
  logic [3:0]  stall_cycles_s, flush_events_s;
  logic        proto_err, proto_err_s;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model state
  longint m_stall, m_flush, m_stall_s, m_flush_s;
  bit     m_perr, m_perr_s, m_prev_freeze;
  int     m_run;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rf_re(id_rf_re),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .wb_rd(wb_rd),
    .wb_rf_we(wb_rf_we), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .mem_ready(mem_ready), .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .proto_err(proto_err)
  );

  hazard_ctrl #(.CNT_W(4), .WAIT_TIMEOUT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rf_re(id_rf_re),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .wb_rd(wb_rd),
    .wb_rf_we(wb_rf_we), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .mem_ready(mem_ready), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .pc_stall(pc_stall_s),
    .ifid_stall(ifid_stall_s), .idex_stall(idex_stall_s), .exmem_stall(exmem_stall_s),
    .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s), .memwb_flush(memwb_flush_s),
    .stall_cycles(stall_cycles_s), .flush_events(flush_events_s), .proto_err(proto_err_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: spec rules in plain terms ----
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (!rst_n) return 2'b00;
    if (mem_rf_we && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_rf_we && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_load_use();
    return ex_is_load && ex_rf_we && ex_rd != 0 &&
           ((id_rf_re[0] && id_rs1 == ex_rd) || (id_rf_re[1] && id_rs2 == ex_rd));
  endfunction

  // {pc, ifid, idex, exmem stalls, ifid, idex, memwb flushes}
  function automatic logic [6:0] m_ctl();
    if (!rst_n)         return 7'b0000_111;
    if (m_freeze())     return 7'b1111_001;
    if (ex_redirect)    return 7'b0000_110;
    if (m_load_use())   return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic m_reset();
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    m_perr = 0; m_perr_s = 0; m_prev_freeze = 0; m_run = 0;
  endtask

  // clock-edge update, using the inputs that were stable across the edge
  task automatic m_edge();
    bit fz;
    if (!rst_n) begin
      m_reset();
      return;
    end
    fz = m_freeze();
    if (m_ctl()[6:3] != 0) begin
      m_stall   = sat_inc(m_stall, 64'hFFFF_FFFF);
      m_stall_s = sat_inc(m_stall_s, 15);
    end
    if (ex_redirect && !fz) begin
      m_flush   = sat_inc(m_flush, 64'hFFFF_FFFF);
      m_flush_s = sat_inc(m_flush_s, 15);
    end
    if (m_prev_freeze && !mem_req) begin
      m_perr = 1; m_perr_s = 1;
    end
    if (fz) begin
      m_run = m_prev_freeze ? m_run + 1 : 1;
      if (m_run >= 64) m_perr = 1;
      if (m_run >= 4)  m_perr_s = 1;
    end else begin
      m_run = 0;
    end
    m_prev_freeze = fz;
  endtask

  task automatic check_all();
    logic [6:0] c;
    c = m_ctl();
    chk("fwd_a", fwd_a, m_fwd(ex_rs1));
    chk("fwd_b", fwd_b, m_fwd(ex_rs2));
    chk("fwd_a_s", fwd_a_s, m_fwd(ex_rs1));
    chk("ctl", {pc_stall, ifid_stall, idex_stall, exmem_stall,
                ifid_flush, idex_flush, memwb_flush}, c);
    chk("ctl_s", {pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s,
                  ifid_flush_s, idex_flush_s, memwb_flush_s}, c);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_events", flush_events, m_flush);
    chk("stall_cycles_s", stall_cycles_s, m_stall_s);
    chk("flush_events_s", flush_events_s, m_flush_s);
    chk("proto_err", proto_err, m_perr);
    chk("proto_err_s", proto_err_s, m_perr_s);
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rf_re = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_rf_we = 0; ex_is_load = 0; mem_rd = 0; mem_rf_we = 0; wb_rd = 0; wb_rf_we = 0;
    ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    idle();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_flush", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
    chk("rst_stall", {pc_stall, ifid_stall, idex_stall, exmem_stall}, 4'b0000);
    step();
    rst_n = 1'b1;
    step();

    // 1: forwarding priority and x0
    mem_rd = 5; mem_rf_we = 1; wb_rd = 5; wb_rf_we = 1; ex_rs1 = 5;
    #1 chk("t1_mem", fwd_a, 2'b01);
    step();
    mem_rf_we = 0;
    #1 chk("t1_wb", fwd_a, 2'b10);
    step();
    mem_rd = 0; mem_rf_we = 1; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    #1 chk("t1_x0", fwd_a, 2'b00);
    step();

    // 2: load-use, single bubble, then forward from WB
    do_reset();
    idle();
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 1; id_rf_re = 2'b11;
    #1 chk("t2_lu", {pc_stall, ifid_stall, idex_flush}, 3'b111);
    step();
    ex_is_load = 0; ex_rf_we = 0; ex_rd = 0; mem_rd = 7; mem_rf_we = 1;
    #1 chk("t2_nostall", pc_stall, 1'b0);
    step();
    idle();
    ex_rs1 = 7; ex_rs2 = 1; wb_rd = 7; wb_rf_we = 1;
    #1 chk("t2_fwd", fwd_a, 2'b10);
    chk("t2_cnt", stall_cycles, 32'd1);
    step();

    // 3: load-use plus redirect -> redirect wins
    do_reset();
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 7; id_rs1 = 7; id_rf_re = 2'b11; ex_redirect = 1;
    #1 chk("t3_ctl", {pc_stall, ifid_stall, ifid_flush, idex_flush}, 4'b0011);
    step();
    idle();
    #1 chk("t3_cnt", flush_events, 32'd1);
    step();

    // 4: 3 freeze cycles, release, redirect held throughout counted once
    do_reset();
    ex_redirect = 1; mem_req = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1;
    #1 chk("t4_rel", exmem_stall, 1'b0);
    step();
    idle();
    #1 chk("t4_stall", stall_cycles, 32'd3);
    chk("t4_flush", flush_events, 32'd1);
    chk("t4_perr", proto_err, 1'b0);
    step();

    // 5: timeout on small instance, then reset mid-wait
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) step();
    chk("t5_pre", proto_err_s, 1'b0);
    step();
    chk("t5_to", proto_err_s, 1'b1);
    step();
    chk("t5_hold", exmem_stall_s, 1'b1);
    rst_n = 1'b0;
    m_reset();
    #1 chk("t5_rst", {pc_stall_s, exmem_stall_s, ifid_flush_s, idex_flush_s,
                      memwb_flush_s, proto_err_s}, 6'b00_111_0);
    step();
    rst_n = 1'b1;
    idle();
    #1 chk("t5_after", {pc_stall_s, exmem_stall_s}, 2'b00);
    step();

    // 6: saturation of 4-bit stall counter
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (20) step();
    chk("t6_sat", stall_cycles_s, 4'd15);
    idle();
    step();

    // randomized run
    do_reset();
    for (int i = 0; i < 500; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rf_re = 2'($urandom);
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); ex_rf_we = 1'($urandom);
      ex_is_load = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_rf_we = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_rf_we = 1'($urandom);
      ex_redirect = ($urandom_range(0, 3) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        m_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
